pll_reconfig_sequencer: RTL and testbench

PLL_RECONFIG_SEQUENCER -- requirements
Module: pll_reconfig_sequencer

---
 rtl/pll_recfg_pkg.sv | 28 ++
 rtl/pll_recfg_timer.sv | 37 +++
 rtl/pll_reconfig_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_reconfig_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_recfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: state encoding,
// default parameter values and a small state-classification helper.
`timescale 1ns/1ps
package pll_recfg_pkg;

    localparam int DEF_N_ROM     = 4;
    localparam int DEF_WR_CYCLES = 1;
    localparam int DEF_SKIP_SAME = 0;
    localparam int DEF_TIMEOUT   = 1024;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        WAIT_LD_HI = 3'd2,
        WAIT_LD_LO = 3'd3,
        RECONFIG   = 3'd4,
        WAIT_RC_HI = 3'd5,
        WAIT_RC_LO = 3'd6,
        ADDR_RST   = 3'd7
    } state_t;

    // True for the four states that sit waiting on the reconfig-core busy flag.
    function automatic logic is_wait_state(input state_t s);
        return (s == WAIT_LD_HI) || (s == WAIT_LD_LO) ||
               (s == WAIT_RC_HI) || (s == WAIT_RC_LO);
    endfunction

endpackage

// File: rtl/pll_recfg_timer.sv
// Watchdog counter for the sequencer's busy-wait states. 'clear' is high on
// the first cycle of a state, so the count restarts on every state entry and
// 'expired' fires during the TIMEOUT-th cycle spent in that state.
`timescale 1ns/1ps
module pll_recfg_timer
    import pll_recfg_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] elapsed;

    assign elapsed = clear ? '0 : count;
    assign expired = enable && (elapsed == LIMIT);

    // Count cycles while a wait state is active, restarting on state entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= elapsed + 1'b1;
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// PLL reconfiguration sequencer: selects a configuration ROM, resets its
// address counter, strobes the scan-chain load, waits on the core busy flag,
// fires reconfigure and waits again. Requests arriving mid-sequence are held
// in a one-deep pending slot (last one wins).
// Optional feature macro: PLL_RECFG_TIMEOUT_EN adds a per-wait-state watchdog
// that aborts to IDLE and raises a sticky error flag.
`timescale 1ns/1ps
module pll_reconfig_sequencer
    import pll_recfg_pkg::*;
#(
    parameter int N_ROM     = DEF_N_ROM,
    parameter int WR_CYCLES = DEF_WR_CYCLES,
    parameter int SKIP_SAME = DEF_SKIP_SAME,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    localparam int SEL_W    = $clog2(N_ROM)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             busy,
    input  logic             req,
    input  logic [SEL_W-1:0] req_rom,
    output logic             req_ack,
    output logic [SEL_W-1:0] mux_sel,
    output logic             rom_addr_rst,
    output logic             write_from_rom,
    output logic             reconfig,
    output logic             done,
    output logic             error,
    output logic [SEL_W-1:0] active_rom,
    output logic [2:0]       current_state
);

    localparam int WR_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [WR_W-1:0] WR_LAST = WR_W'(WR_CYCLES - 1);

    state_t           state;
    logic             pend_valid;
    logic [SEL_W-1:0] pend_rom;
    logic [SEL_W-1:0] accept_rom;
    logic             skip_hit;
    logic [WR_W-1:0]  load_cnt;
    logic             tmr_expired;

    assign current_state = state;
    assign accept_rom    = pend_valid ? pend_rom : req_rom;
    assign skip_hit      = (SKIP_SAME != 0) && (accept_rom == active_rom) && !error;

    // Nonsensical parameter sets leave a visible marker in the hierarchy.
    if (N_ROM < 2 || WR_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
    end

`ifdef PLL_RECFG_TIMEOUT_EN
    state_t state_d;

    pll_recfg_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != state_d),
        .enable  (is_wait_state(state)),
        .expired (tmr_expired)
    );

    // Previous state lets the watchdog see every state entry; error is sticky until the next accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_d <= IDLE;
            error   <= 1'b0;
        end else begin
            state_d <= state;
            if (state == IDLE && (pend_valid || req)) begin
                error <= 1'b0;
            end else if (tmr_expired) begin
                error <= 1'b1;
            end
        end
    end
`else
    assign tmr_expired = 1'b0;
    assign error       = 1'b0;
`endif

    // Main sequencer: state, mux select, pending slot and all registered pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            mux_sel        <= '0;
            active_rom     <= '0;
            pend_valid     <= 1'b0;
            pend_rom       <= '0;
            load_cnt       <= '0;
            req_ack        <= 1'b0;
            rom_addr_rst   <= 1'b0;
            write_from_rom <= 1'b0;
            reconfig       <= 1'b0;
            done           <= 1'b0;
        end else begin
            req_ack        <= 1'b0;
            rom_addr_rst   <= 1'b0;
            write_from_rom <= 1'b0;
            reconfig       <= 1'b0;
            done           <= 1'b0;

            if (state != IDLE && req) begin
                pend_valid <= 1'b1;
                pend_rom   <= req_rom;
            end

            case (state)
                IDLE: begin
                    if (pend_valid || req) begin
                        req_ack    <= 1'b1;
                        mux_sel    <= accept_rom;
                        pend_valid <= 1'b0;
                        if (skip_hit) begin
                            done <= 1'b1;
                        end else begin
                            state <= ADDR_RST;
                        end
                    end
                end
                ADDR_RST: begin
                    rom_addr_rst <= 1'b1;
                    load_cnt     <= '0;
                    state        <= LOAD;
                end
                LOAD: begin
                    write_from_rom <= 1'b1;
                    if (load_cnt == WR_LAST) begin
                        state <= WAIT_LD_HI;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                WAIT_LD_HI: if (busy) state <= WAIT_LD_LO;
                WAIT_LD_LO: if (!busy) state <= RECONFIG;
                RECONFIG: begin
                    reconfig <= 1'b1;
                    state    <= WAIT_RC_HI;
                end
                WAIT_RC_HI: if (busy) state <= WAIT_RC_LO;
                WAIT_RC_LO: begin
                    if (!busy) begin
                        done       <= 1'b1;
                        active_rom <= mux_sel;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (tmr_expired) begin
                state      <= IDLE;
                done       <= 1'b0;
                active_rom <= active_rom;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Testbench for pll_reconfig_sequencer. A behavioural PLL core raises busy
// three cycles after each strobe; a scoreboard queue holds the ROM expected
// in active_rom at every done pulse.
`timescale 1ns/1ps
module tb_pll_reconfig_sequencer;
    import pll_recfg_pkg::*;

    localparam int N_ROM     = 4;
    localparam int WR_CYCLES = 2;
    localparam int SKIP_SAME = 1;
    localparam int TIMEOUT   = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic       req = 1'b0;
    logic [1:0] req_rom = 2'd0;
    logic       req_ack, rom_addr_rst, write_from_rom, reconfig, done, error;
    logic [1:0] mux_sel, active_rom;
    logic [2:0] current_state;

    logic pll_en = 1'b0;
    logic model_busy = 1'b0;
    logic man_busy = 1'b0;
    assign busy = pll_en ? model_busy : man_busy;

    int checks = 0;
    int passed = 0;
    logic [1:0] exp_q[$];

    always #5 clock = ~clock;

    pll_reconfig_sequencer #(
        .N_ROM(N_ROM), .WR_CYCLES(WR_CYCLES), .SKIP_SAME(SKIP_SAME), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .busy(busy), .req(req), .req_rom(req_rom),
        .req_ack(req_ack), .mux_sel(mux_sel), .rom_addr_rst(rom_addr_rst),
        .write_from_rom(write_from_rom), .reconfig(reconfig), .done(done),
        .error(error), .active_rom(active_rom), .current_state(current_state)
    );

    // Behavioural PLL core: busy goes high for two cycles, three cycles after a strobe.
    initial begin : pll_model
        int dly;
        int hi;
        logic wr_prev;
        dly = 0;
        hi = 0;
        wr_prev = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (dly > 0) begin
                dly--;
                if (dly == 0) hi = 2;
            end
            if (hi > 0) begin
                model_busy = 1'b1;
                hi--;
            end else begin
                model_busy = 1'b0;
            end
            if (pll_en && ((write_from_rom && !wr_prev) || reconfig)) dly = 3;
            wr_prev = write_from_rom;
            if (!pll_en) begin
                dly = 0;
                hi = 0;
                model_busy = 1'b0;
            end
        end
    end

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL done_unexpected: done=1 active_rom=%0d with no request outstanding", active_rom);
            end else begin
                logic [1:0] exp_rom;
                exp_rom = exp_q.pop_front();
                if (active_rom !== exp_rom)
                    $display("[TB] FAIL sb_active_rom: got %0d want %0d", active_rom, exp_rom);
                else
                    passed++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input state_t s, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (current_state == s) break;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 1'b0;
        repeat (3) tick();
        checks++; if (current_state !== 3'd0) $display("[TB] FAIL reset_state: got %0d want 0", current_state); else passed++;
        checks++; if (mux_sel !== 2'd0) $display("[TB] FAIL reset_mux_sel: got %0d want 0", mux_sel); else passed++;
        checks++; if (active_rom !== 2'd0) $display("[TB] FAIL reset_active_rom: got %0d want 0", active_rom); else passed++;
        checks++;
        if ({req_ack, rom_addr_rst, write_from_rom, reconfig, done, error} !== 6'b0)
            $display("[TB] FAIL reset_pulses: got %b want 000000", {req_ack, rom_addr_rst, write_from_rom, reconfig, done, error});
        else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_request();
        int n_rc;
        int n_done;
        n_rc = 0;
        n_done = 0;
        pll_en = 1'b1;
        req_rom = 2'd2;
        req = 1'b1;
        exp_q.push_back(2'd2);
        tick();
        req = 1'b0;
        checks++; if (req_ack !== 1'b1) $display("[TB] FAIL basic_ack_c0: got %b want 1", req_ack); else passed++;
        checks++; if (mux_sel !== 2'd2) $display("[TB] FAIL basic_mux_sel: got %0d want 2", mux_sel); else passed++;
        tick();
        checks++; if ({req_ack, rom_addr_rst} !== 2'b01) $display("[TB] FAIL basic_addr_rst_c1: got ack,rst=%b want 01", {req_ack, rom_addr_rst}); else passed++;
        tick();
        checks++; if (write_from_rom !== 1'b1) $display("[TB] FAIL basic_wr_c2: got %b want 1", write_from_rom); else passed++;
        tick();
        checks++; if (write_from_rom !== 1'b1) $display("[TB] FAIL basic_wr_c3: got %b want 1", write_from_rom); else passed++;
        tick();
        checks++; if (write_from_rom !== 1'b0) $display("[TB] FAIL basic_wr_c4: got %b want 0", write_from_rom); else passed++;
        repeat (40) begin
            tick();
            if (reconfig) n_rc++;
            if (done) n_done++;
        end
        checks++; if (n_rc !== 1) $display("[TB] FAIL basic_reconfig_count: got %0d want 1", n_rc); else passed++;
        checks++; if (n_done !== 1) $display("[TB] FAIL basic_done_count: got %0d want 1", n_done); else passed++;
        checks++; if (active_rom !== 2'd2) $display("[TB] FAIL basic_active_rom: got %0d want 2", active_rom); else passed++;
        checks++; if (current_state !== 3'd0) $display("[TB] FAIL basic_end_state: got %0d want 0", current_state); else passed++;
    endtask

    task automatic test_pending();
        int n_ack;
        int n_done;
        logic [1:0] ack_sel;
        n_ack = 0;
        n_done = 0;
        ack_sel = 2'd0;
        pll_en = 1'b1;
        req_rom = 2'd0;
        req = 1'b1;
        exp_q.push_back(2'd0);
        tick();
        req = 1'b0;
        checks++; if (req_ack !== 1'b1) $display("[TB] FAIL pend_first_ack: got %b want 1", req_ack); else passed++;
        wait_state(WAIT_LD_LO, 40);
        checks++; if (current_state !== 3'd3) $display("[TB] FAIL pend_reach_ld_lo: got %0d want 3", current_state); else passed++;
        req_rom = 2'd1;
        req = 1'b1;
        tick();
        req = 1'b0;
        checks++; if (req_ack !== 1'b0) $display("[TB] FAIL pend_no_early_ack: got %b want 0", req_ack); else passed++;
        wait_state(WAIT_RC_HI, 40);
        checks++; if (current_state !== 3'd5) $display("[TB] FAIL pend_reach_rc_hi: got %0d want 5", current_state); else passed++;
        req_rom = 2'd3;
        req = 1'b1;
        exp_q.push_back(2'd3);
        tick();
        req = 1'b0;
        repeat (60) begin
            tick();
            if (req_ack) begin
                n_ack++;
                ack_sel = mux_sel;
            end
            if (done) n_done++;
        end
        checks++; if (n_ack !== 1) $display("[TB] FAIL pend_ack_count: got %0d want 1", n_ack); else passed++;
        checks++; if (ack_sel !== 2'd3) $display("[TB] FAIL pend_mux_sel: got %0d want 3", ack_sel); else passed++;
        checks++; if (n_done !== 2) $display("[TB] FAIL pend_done_count: got %0d want 2", n_done); else passed++;
        checks++; if (active_rom !== 2'd3) $display("[TB] FAIL pend_active_rom: got %0d want 3", active_rom); else passed++;
    endtask

    task automatic test_reset_in_flight();
        int n_done;
        n_done = 0;
        pll_en = 1'b0;
        man_busy = 1'b0;
        req_rom = 2'd1;
        req = 1'b1;
        exp_q.push_back(2'd1);
        tick();
        req = 1'b0;
        wait_state(WAIT_LD_HI, 20);
        man_busy = 1'b1;
        wait_state(WAIT_LD_LO, 5);
        man_busy = 1'b0;
        wait_state(WAIT_RC_HI, 5);
        man_busy = 1'b1;
        wait_state(WAIT_RC_LO, 5);
        checks++; if (current_state !== 3'd6) $display("[TB] FAIL rif_reach_rc_lo: got %0d want 6", current_state); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        man_busy = 1'b0;
        exp_q.delete();
        checks++; if (current_state !== 3'd0) $display("[TB] FAIL rif_state: got %0d want 0", current_state); else passed++;
        checks++; if (mux_sel !== 2'd0) $display("[TB] FAIL rif_mux_sel: got %0d want 0", mux_sel); else passed++;
        checks++; if (active_rom !== 2'd0) $display("[TB] FAIL rif_active_rom: got %0d want 0", active_rom); else passed++;
        if (done) n_done++;
        repeat (5) begin
            tick();
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) $display("[TB] FAIL rif_no_done: got %0d done pulses want 0", n_done); else passed++;
    endtask

    task automatic test_req_through_reset();
        int n_done;
        n_done = 0;
        pll_en = 1'b1;
        reset = 1'b1;
        req_rom = 2'd2;
        req = 1'b1;
        repeat (2) tick();
        checks++; if (req_ack !== 1'b0) $display("[TB] FAIL rtr_ack_in_reset: got %b want 0", req_ack); else passed++;
        reset = 1'b0;
        exp_q.push_back(2'd2);
        tick();
        req = 1'b0;
        checks++; if (req_ack !== 1'b1) $display("[TB] FAIL rtr_first_cycle_ack: got %b want 1", req_ack); else passed++;
        checks++; if (mux_sel !== 2'd2) $display("[TB] FAIL rtr_mux_sel: got %0d want 2", mux_sel); else passed++;
        repeat (40) begin
            tick();
            if (done) n_done++;
        end
        checks++; if (n_done !== 1) $display("[TB] FAIL rtr_done_count: got %0d want 1", n_done); else passed++;
        checks++; if (active_rom !== 2'd2) $display("[TB] FAIL rtr_active_rom: got %0d want 2", active_rom); else passed++;
    endtask

    task automatic test_skip_same();
        int n_wr;
        int n_rc;
        n_wr = 0;
        n_rc = 0;
        pll_en = 1'b1;
        req_rom = 2'd2;
        req = 1'b1;
        exp_q.push_back(2'd2);
        tick();
        req = 1'b0;
        checks++; if ({req_ack, done} !== 2'b11) $display("[TB] FAIL skip_ack_done: got ack,done=%b want 11", {req_ack, done}); else passed++;
        checks++; if (current_state !== 3'd0) $display("[TB] FAIL skip_state: got %0d want 0", current_state); else passed++;
        repeat (6) begin
            tick();
            if (write_from_rom) n_wr++;
            if (reconfig) n_rc++;
        end
        checks++; if (n_wr + n_rc !== 0) $display("[TB] FAIL skip_no_sequence: got wr=%0d rc=%0d want 0 0", n_wr, n_rc); else passed++;
    endtask

`ifdef PLL_RECFG_TIMEOUT_EN
    task automatic test_timeout();
        int n_wait;
        int n_done;
        n_wait = 0;
        n_done = 0;
        pll_en = 1'b0;
        man_busy = 1'b0;
        req_rom = 2'd1;
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_state(WAIT_LD_HI, 20);
        while (current_state == 3'd2 && n_wait < 40) begin
            n_wait++;
            tick();
            if (done) n_done++;
        end
        checks++; if (n_wait !== TIMEOUT) $display("[TB] FAIL to_wait_cycles: got %0d want %0d", n_wait, TIMEOUT); else passed++;
        checks++; if (current_state !== 3'd0) $display("[TB] FAIL to_state: got %0d want 0", current_state); else passed++;
        checks++; if (error !== 1'b1) $display("[TB] FAIL to_error: got %b want 1", error); else passed++;
        checks++; if (n_done !== 0) $display("[TB] FAIL to_no_done: got %0d want 0", n_done); else passed++;
        checks++; if (active_rom !== 2'd2) $display("[TB] FAIL to_active_rom: got %0d want 2", active_rom); else passed++;
        pll_en = 1'b1;
        req = 1'b1;
        exp_q.push_back(2'd1);
        tick();
        req = 1'b0;
        checks++; if (error !== 1'b0) $display("[TB] FAIL to_error_clear: got %b want 0", error); else passed++;
        repeat (40) tick();
        checks++; if (active_rom !== 2'd1) $display("[TB] FAIL to_recover_rom: got %0d want 1", active_rom); else passed++;
    endtask
`else
    task automatic test_no_timeout();
        pll_en = 1'b0;
        man_busy = 1'b0;
        req_rom = 2'd1;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (40) tick();
        checks++; if (current_state !== 3'd2) $display("[TB] FAIL nto_still_waiting: got %0d want 2", current_state); else passed++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL nto_error: got %b want 0", error); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask
`endif

    initial begin
        $display("[TB] starting pll_reconfig_sequencer bench");
        test_reset();
        test_basic_request();
        test_pending();
        test_reset_in_flight();
        test_req_through_reset();
        test_skip_same();
`ifdef PLL_RECFG_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
